// File: rtl/tlb_pkg.sv
// TLB shared definitions: field widths, entry packing layout and page-select helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  // One dual-page entry. Field order fixes the bit-packing of the storage array.
  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  // The half of an entry that a search returns.
  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_page_t;

  // VA[12] picks the odd page of the pair.
  function automatic tlb_page_t page_of(input tlb_entry_t ent, input logic odd);
    tlb_page_t pg;
    if (odd) begin
      pg.pfn = ent.pfn1;
      pg.c   = ent.c1;
      pg.d   = ent.d1;
      pg.v   = ent.v1;
    end else begin
      pg.pfn = ent.pfn0;
      pg.c   = ent.c0;
      pg.d   = ent.d0;
      pg.v   = ent.v0;
    end
    return pg;
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// One TLB search port: parallel match, lowest-index priority encode, page select, output register.
// Latency: 1 cycle from req to valid; fully pipelined, one request per cycle.
// Backpressure: none; results hold until the next req, valid pulses for one cycle per req.
//
// Ports: clk/reset; entries/entry_e = storage array and entry-valid bits from the top;
//        req/vpn2/odd_page/asid = search request; valid/found/index/pfn/c/d/v = registered result.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  tlb_entry_t [TLBNUM-1:0]       entries,
  input  logic [TLBNUM-1:0]             entry_e,
  input  logic                          req,
  input  logic [VPN2_W-1:0]             vpn2,
  input  logic                          odd_page,
  input  logic [ASID_W-1:0]             asid,
  output logic                          valid,
  output logic                          found,
  output logic [TLBNUM_WIDTH-1:0]       index,
  output logic [PFN_W-1:0]              pfn,
  output logic [C_W-1:0]                c,
  output logic                          d,
  output logic                          v
);

  logic [TLBNUM-1:0]       match;
  logic                    hit;
  logic [TLBNUM_WIDTH-1:0] hit_idx;
  tlb_page_t               hit_page;

  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = entry_e[i] && (entries[i].vpn2 == vpn2) &&
                 (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = TLBNUM_WIDTH'(i);
      end
    end
  end

  // A miss must report an all-zero page, not whatever entry 0 holds.
  always_comb begin
    hit_page = '0;
    if (hit) begin
      hit_page = page_of(entries[hit_idx], odd_page);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      found <= 1'b0;
      index <= '0;
      pfn   <= '0;
      c     <= '0;
      d     <= 1'b0;
      v     <= 1'b0;
    end else begin
      valid <= req;
      if (req) begin
        found <= hit;
        index <= hit_idx;
        pfn   <= hit_page.pfn;
        c     <= hit_page.c;
        d     <= hit_page.d;
        v     <= hit_page.v;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// Joint TLB: entry storage with CP0 write/read ports and two independent registered search ports.
// Latency: search 1 cycle (pipelined); write takes effect at the edge; read is combinational.
// Backpressure: none; every port accepts a request every cycle.
//
// Ports: clk/reset; s0_* = fetch search; s1_* = data/TLBP search plus s1_probe = {~found, index};
//        we/w_* = TLBWI/TLBWR write; r_index/r_* = TLBR read of the entry at r_index.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  // search port 0
  input  logic                    s0_req,
  input  logic [VPN2_W-1:0]       s0_vpn2,
  input  logic                    s0_odd_page,
  input  logic [ASID_W-1:0]       s0_asid,
  output logic                    s0_valid,
  output logic                    s0_found,
  output logic [TLBNUM_WIDTH-1:0] s0_index,
  output logic [PFN_W-1:0]        s0_pfn,
  output logic [C_W-1:0]          s0_c,
  output logic                    s0_d,
  output logic                    s0_v,
  // search port 1
  input  logic                    s1_req,
  input  logic [VPN2_W-1:0]       s1_vpn2,
  input  logic                    s1_odd_page,
  input  logic [ASID_W-1:0]       s1_asid,
  output logic                    s1_valid,
  output logic                    s1_found,
  output logic [TLBNUM_WIDTH-1:0] s1_index,
  output logic [PFN_W-1:0]        s1_pfn,
  output logic [C_W-1:0]          s1_c,
  output logic                    s1_d,
  output logic                    s1_v,
  output logic [TLBNUM_WIDTH:0]   s1_probe,
  // write port
  input  logic                    we,
  input  logic [TLBNUM_WIDTH-1:0] w_index,
  input  logic [VPN2_W-1:0]       w_vpn2,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic                    w_g,
  input  logic [PFN_W-1:0]        w_pfn0,
  input  logic [C_W-1:0]          w_c0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [PFN_W-1:0]        w_pfn1,
  input  logic [C_W-1:0]          w_c1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  // read port
  input  logic [TLBNUM_WIDTH-1:0] r_index,
  output logic [VPN2_W-1:0]       r_vpn2,
  output logic [ASID_W-1:0]       r_asid,
  output logic                    r_g,
  output logic [PFN_W-1:0]        r_pfn0,
  output logic [C_W-1:0]          r_c0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [PFN_W-1:0]        r_pfn1,
  output logic [C_W-1:0]          r_c1,
  output logic                    r_d1,
  output logic                    r_v1
);

  tlb_entry_t [TLBNUM-1:0] entries;
  logic       [TLBNUM-1:0] entry_e;
  tlb_entry_t              w_ent;
  tlb_entry_t              r_ent;

  always_comb begin
    w_ent      = '0;
    w_ent.vpn2 = w_vpn2;
    w_ent.asid = w_asid;
    w_ent.g    = w_g;
    w_ent.pfn0 = w_pfn0;
    w_ent.c0   = w_c0;
    w_ent.d0   = w_d0;
    w_ent.v0   = w_v0;
    w_ent.pfn1 = w_pfn1;
    w_ent.c1   = w_c1;
    w_ent.d1   = w_d1;
    w_ent.v1   = w_v1;
  end

  // Searches in the write cycle read the pre-edge array, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
      entry_e <= '0;
    end else if (we) begin
      entries[w_index] <= w_ent;
      entry_e[w_index] <= 1'b1;
    end
  end

  assign r_ent  = entries[r_index];
  assign r_vpn2 = r_ent.vpn2;
  assign r_asid = r_ent.asid;
  assign r_g    = r_ent.g;
  assign r_pfn0 = r_ent.pfn0;
  assign r_c0   = r_ent.c0;
  assign r_d0   = r_ent.d0;
  assign r_v0   = r_ent.v0;
  assign r_pfn1 = r_ent.pfn1;
  assign r_c1   = r_ent.c1;
  assign r_d1   = r_ent.d1;
  assign r_v1   = r_ent.v1;

  tlb_lookup #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_lookup0 (
    .clk      (clk),
    .reset    (reset),
    .entries  (entries),
    .entry_e  (entry_e),
    .req      (s0_req),
    .vpn2     (s0_vpn2),
    .odd_page (s0_odd_page),
    .asid     (s0_asid),
    .valid    (s0_valid),
    .found    (s0_found),
    .index    (s0_index),
    .pfn      (s0_pfn),
    .c        (s0_c),
    .d        (s0_d),
    .v        (s0_v)
  );

  tlb_lookup #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_lookup1 (
    .clk      (clk),
    .reset    (reset),
    .entries  (entries),
    .entry_e  (entry_e),
    .req      (s1_req),
    .vpn2     (s1_vpn2),
    .odd_page (s1_odd_page),
    .asid     (s1_asid),
    .valid    (s1_valid),
    .found    (s1_found),
    .index    (s1_index),
    .pfn      (s1_pfn),
    .c        (s1_c),
    .d        (s1_d),
    .v        (s1_v)
  );

  // P bit set means the probe missed.
  assign s1_probe = {~s1_found, s1_index};

endmodule

// File: tb/tb_tlb.sv
module tb_tlb;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic s0_req, s0_odd_page, s1_req, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic [7:0]  s0_asid, s1_asid;
  logic s0_valid, s0_found, s0_d, s0_v, s1_valid, s1_found, s1_d, s1_v;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic [IW:0] s1_probe;
  logic we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IW-1:0] w_index, r_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;

  tlb #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_valid(s0_valid), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_valid(s1_valid), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v), .s1_probe(s1_probe),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  // ---------------- reference model ----------------
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic        m_g    [N];
  logic        m_e    [N];
  logic [19:0] m_pfn  [N][2];
  logic [2:0]  m_c    [N][2];
  logic        m_d    [N][2];
  logic        m_v    [N][2];

  logic          x_valid [2];
  logic          x_found [2];
  logic [IW-1:0] x_index [2];
  logic [19:0]   x_pfn   [2];
  logic [2:0]    x_c     [2];
  logic          x_d     [2];
  logic          x_v     [2];
  bit started = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_search(input int p, input logic req, input logic [18:0] vpn,
                              input logic odd, input logic [7:0] asid);
    int hit;
    x_valid[p] = req;
    if (!req) return;
    hit = -1;
    for (int i = 0; i < N; i++)
      if (hit < 0 && m_e[i] && m_vpn2[i] == vpn && (m_g[i] || m_asid[i] == asid)) hit = i;
    if (hit < 0) begin
      x_found[p] = 0; x_index[p] = 0; x_pfn[p] = 0; x_c[p] = 0; x_d[p] = 0; x_v[p] = 0;
    end else begin
      x_found[p] = 1; x_index[p] = IW'(hit);
      x_pfn[p] = m_pfn[hit][odd]; x_c[p] = m_c[hit][odd];
      x_d[p] = m_d[hit][odd];     x_v[p] = m_v[hit][odd];
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      for (int i = 0; i < N; i++) begin
        m_vpn2[i] = 0; m_asid[i] = 0; m_g[i] = 0; m_e[i] = 0;
        for (int k = 0; k < 2; k++) begin
          m_pfn[i][k] = 0; m_c[i][k] = 0; m_d[i][k] = 0; m_v[i][k] = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        x_valid[p] = 0; x_found[p] = 0; x_index[p] = 0; x_pfn[p] = 0;
        x_c[p] = 0; x_d[p] = 0; x_v[p] = 0;
      end
    end else if (started) begin
      // searches see the array as it was before this edge's write
      model_search(0, s0_req, s0_vpn2, s0_odd_page, s0_asid);
      model_search(1, s1_req, s1_vpn2, s1_odd_page, s1_asid);
      if (we) begin
        m_e[w_index] = 1; m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid; m_g[w_index] = w_g;
        m_pfn[w_index][0] = w_pfn0; m_c[w_index][0] = w_c0; m_d[w_index][0] = w_d0; m_v[w_index][0] = w_v0;
        m_pfn[w_index][1] = w_pfn1; m_c[w_index][1] = w_c1; m_d[w_index][1] = w_d1; m_v[w_index][1] = w_v1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_port(input int p, input logic vl, input logic fd, input logic [IW-1:0] ix,
                          input logic [19:0] pf, input logic [2:0] cc, input logic dd, input logic vv);
    chk($sformatf("s%0d_valid", p), 32'(vl), 32'(x_valid[p]));
    chk($sformatf("s%0d_found", p), 32'(fd), 32'(x_found[p]));
    chk($sformatf("s%0d_index", p), 32'(ix), 32'(x_index[p]));
    chk($sformatf("s%0d_pfn", p),   32'(pf), 32'(x_pfn[p]));
    chk($sformatf("s%0d_c", p),     32'(cc), 32'(x_c[p]));
    chk($sformatf("s%0d_d", p),     32'(dd), 32'(x_d[p]));
    chk($sformatf("s%0d_v", p),     32'(vv), 32'(x_v[p]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_port(0, s0_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v);
      cmp_port(1, s1_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v);
      chk("s1_probe", 32'(s1_probe), 32'({~x_found[1], x_index[1]}));
      chk("r_vpn2", 32'(r_vpn2), 32'(m_vpn2[r_index]));
      chk("r_asid", 32'(r_asid), 32'(m_asid[r_index]));
      chk("r_g",    32'(r_g),    32'(m_g[r_index]));
      chk("r_page0", 32'({r_pfn0, r_c0, r_d0, r_v0}),
          32'({m_pfn[r_index][0], m_c[r_index][0], m_d[r_index][0], m_v[r_index][0]}));
      chk("r_page1", 32'({r_pfn1, r_c1, r_d1, r_v1}),
          32'({m_pfn[r_index][1], m_c[r_index][1], m_d[r_index][1], m_v[r_index][1]}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; s0_req = 0; s1_req = 0;
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [18:0] vpn, input logic [7:0] asid,
                    input logic g, input logic [19:0] p0, input logic [2:0] c0, input logic d0,
                    input logic v0, input logic [19:0] p1, input logic [2:0] c1, input logic d1,
                    input logic v1);
    we = 1; w_index = idx; w_vpn2 = vpn; w_asid = asid; w_g = g;
    w_pfn0 = p0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = p1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic srch(input int p, input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
    if (p == 0) begin s0_req = 1; s0_vpn2 = vpn; s0_odd_page = odd; s0_asid = asid; end
    else        begin s1_req = 1; s1_vpn2 = vpn; s1_odd_page = odd; s1_asid = asid; end
  endtask

  initial begin
    reset = 1; r_index = 3;
    idle();
    wr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); we = 0;
    srch(0, 0, 0, 0); srch(1, 0, 0, 0); s0_req = 0; s1_req = 0;
    tick(); tick();
    reset = 0;

    // search on an empty TLB
    srch(0, 19'h0, 0, 8'h0); srch(1, 19'h0, 0, 8'h0);
    tick();
    chk("lit_empty_valid", 32'(s0_valid), 32'd1);
    chk("lit_empty_found", 32'(s0_found), 32'd0);
    chk("lit_empty_probe", 32'(s1_probe), 32'b1_0000);
    chk("lit_empty_read",  32'({r_vpn2, r_pfn0, r_v1}), 32'd0);

    // entry 5, asid-private
    idle();
    wr(5, 19'h12345, 8'h07, 0, 20'hAAAAA, 3, 1, 1, 20'h55555, 0, 0, 0);
    r_index = 5;
    tick();
    chk("lit_read5_pfn0", 32'(r_pfn0), 32'hAAAAA);
    idle();
    srch(0, 19'h12345, 0, 8'h07); srch(1, 19'h12345, 1, 8'h07);
    tick();
    chk("lit_hit5_found", 32'(s0_found), 32'd1);
    chk("lit_hit5_index", 32'(s0_index), 32'd5);
    chk("lit_hit5_page0", 32'({s0_pfn, s0_c, s0_d, s0_v}), 32'({20'hAAAAA, 3'd3, 1'b1, 1'b1}));
    chk("lit_hit5_pfn1",  32'(s1_pfn), 32'h55555);
    chk("lit_hit5_v1",    32'({s1_found, s1_v}), 32'b10);
    srch(1, 19'h12345, 0, 8'h08);
    tick();
    chk("lit_asid_miss_probe", 32'(s1_probe), 32'b1_0000);

    // global entry at 2, duplicate at 9
    idle();
    wr(2, 19'h00400, 8'h33, 1, 20'h11111, 2, 0, 1, 20'h22222, 1, 1, 1);
    tick();
    idle();
    wr(9, 19'h00400, 8'h99, 0, 20'h99999, 0, 0, 1, 0, 0, 0, 0);
    srch(0, 19'h00400, 0, 8'hC4);
    tick();
    chk("lit_global_index", 32'({s0_found, s0_index}), 32'({1'b1, 4'd2}));
    idle();
    srch(0, 19'h00400, 1, 8'h99);
    tick();
    chk("lit_lowest_index", 32'(s0_index), 32'd2);

    // write and search of the same entry on one edge
    idle();
    wr(4, 19'h0ABCD, 8'h01, 0, 20'h44444, 5, 1, 1, 20'h0, 0, 0, 0);
    srch(0, 19'h0ABCD, 0, 8'h01);
    r_index = 4;
    tick();
    chk("lit_same_edge_miss", 32'(s0_found), 32'd0);
    chk("lit_same_edge_read", 32'(r_vpn2), 32'h0ABCD);
    idle();
    srch(0, 19'h0ABCD, 0, 8'h01);
    tick();
    chk("lit_next_edge_hit", 32'({s0_found, s0_index}), 32'({1'b1, 4'd4}));
    idle();
    tick();
    chk("lit_hold_valid", 32'({s0_valid, s0_index}), 32'({1'b0, 4'd4}));

    // both ports every cycle, reset in the middle
    for (int k = 0; k < 8; k++) begin
      idle();
      srch(0, 19'h12345, k[0], 8'h07);
      srch(1, 19'h00400, k[1], 8'(k));
      reset = (k == 5);
      tick();
      if (k == 5) begin
        chk("lit_reset_s0", 32'({s0_valid, s0_found, s0_index, s0_pfn[7:0]}), 32'd0);
        chk("lit_reset_probe", 32'(s1_probe), 32'b1_0000);
      end
    end
    reset = 0;
    idle();
    srch(0, 19'h12345, 0, 8'h07);
    tick();
    chk("lit_after_reset_miss", 32'(s0_found), 32'd0);

    // randomized traffic over a small vpn2/asid space to force hits and collisions
    for (int k = 0; k < 1500; k++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        wr(IW'($urandom_range(0, N - 1)), 19'($urandom_range(0, 7)), 8'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) != 0)
        srch(0, 19'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) != 0)
        srch(1, 19'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(0, 3)));
      r_index = IW'($urandom_range(0, N - 1));
      tick();
    end
    reset = 0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
